uart_tx_sched: RTL and testbench

Transmit scheduler for the single `uart_tx_8n1` transmitter. It shares the transmitter between two byte requesters: port 0 carries echo/response bytes, and port 1 carries status/heartbeat bytes such as ASCII '0'..'9'. It runs in the `hwclk` domain and sequences each byte through the transmitter's send/done handshake. That handshake runs on the slow baud clock, so the scheduler synchronises the done signal and applies a watchdog timeout.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_sched_sync2.sv | 28 ++
 rtl/uart_tx_sched.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding
// and ASCII digit constants used by the status/heartbeat requester.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

  localparam logic [7:0] ASCII_0 = 8'd48;
  localparam logic [7:0] ASCII_9 = 8'd57;

  // True when the byte is an ASCII decimal digit '0'..'9'.
  function automatic logic is_ascii_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/uart_tx_sched_sync2.sv
// Two-flop synchronizer with a configurable reset value, for bringing a
// single asynchronous level into the local clock domain.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture; both stages come out of reset at RST_VAL.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_tx_sched.sv
// Transmit scheduler sharing one uart_tx_8n1 between two byte requesters.
// Port 0: echo/response bytes, port 1: status/heartbeat bytes.
// The transmitter's done signal is synchronised and each handshake phase
// is guarded by a saturating watchdog counter.
// Optional build macro: UART_TX_SCHED_RR_EN selects round-robin
// arbitration; without it requester 0 has fixed priority.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned TO_W           = 17
) (
  input  logic       hwclk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] tx_byte,
  output logic       tx_send,
  input  logic       tx_done_in,
  output logic       busy,
  output logic       grant_id,
  output logic       timeout_err,
  input  logic       err_clr
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  tx_state_e       state_q;
  logic            req0_ready_q;
  logic            req1_ready_q;
  logic [7:0]      tx_byte_q;
  logic            tx_send_q;
  logic            busy_q;
  logic            grant_q;
  logic            err_q;
  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;
  logic            to_hit;
  logic            done_s;
  logic            any_valid;
  logic            win_id;
`ifdef UART_TX_SCHED_RR_EN
  logic            last_q;
`endif

  sync2 #(
    .RST_VAL(1'b1)
  ) u_done_sync (
    .clk_i (hwclk),
    .rst_ni(rst_n),
    .d_i   (tx_done_in),
    .q_o   (done_s)
  );

  // Winner selection for the next grant.
  always_comb begin
    any_valid = req0_valid | req1_valid;
`ifdef UART_TX_SCHED_RR_EN
    // Last winner yields on a tie; a lone requester always wins.
    if (req0_valid && req1_valid) begin
      win_id = ~last_q;
    end else begin
      win_id = ~req0_valid;
    end
`else
    win_id = ~req0_valid;
`endif
  end

  // Saturating watchdog increment and terminal-count detect.
  always_comb begin
    cnt_d  = (cnt_q == TO_LIMIT) ? cnt_q : cnt_q + TO_W'(1);
    to_hit = (cnt_d == TO_LIMIT);
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req0_ready_q <= 1'b0;
      req1_ready_q <= 1'b0;
      tx_byte_q    <= '0;
      tx_send_q    <= 1'b0;
      busy_q       <= 1'b0;
      grant_q      <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
`ifdef UART_TX_SCHED_RR_EN
      last_q       <= 1'b1;
`endif
    end else begin
      req0_ready_q <= 1'b0;
      req1_ready_q <= 1'b0;
      // A timeout set below overrides this clear in the same cycle.
      if (err_clr) begin
        err_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (any_valid && done_s) begin
            req0_ready_q <= ~win_id;
            req1_ready_q <= win_id;
            tx_byte_q    <= win_id ? req1_data : req0_data;
            grant_q      <= win_id;
            busy_q       <= 1'b1;
            state_q      <= LOAD;
`ifdef UART_TX_SCHED_RR_EN
            last_q       <= win_id;
`endif
          end
        end
        LOAD: begin
          tx_send_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!done_s) begin
            tx_send_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= WAIT_DONE;
          end else if (to_hit) begin
            err_q     <= 1'b1;
            tx_send_q <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= cnt_d;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        WAIT_DONE: begin
          if (done_s) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (to_hit) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= cnt_d;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          tx_send_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready  = req0_ready_q;
  assign req1_ready  = req1_ready_q;
  assign tx_byte     = tx_byte_q;
  assign tx_send     = tx_send_q;
  assign busy        = busy_q;
  assign grant_id    = grant_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: table of single transfers against a
// behavioural transmitter, plus reset, start-gating and timeout sequences.
module tb_uart_tx_sched;

  logic       hwclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req1_ready;
  logic [7:0] tx_byte;
  logic       tx_send;
  logic       tx_done_in;
  logic       busy;
  logic       grant_id;
  logic       timeout_err;
  logic       err_clr = 1'b0;

  // second instance, short watchdog, transmitter that never answers
  logic       t_req0_valid = 1'b0;
  logic [7:0] t_req0_data = 8'h00;
  logic       t_req0_ready;
  logic       t_req1_ready;
  logic [7:0] t_tx_byte;
  logic       t_tx_send;
  logic       t_busy;
  logic       t_grant_id;
  logic       t_timeout_err;
  logic       t_err_clr = 1'b0;

  logic auto_en  = 1'b1;
  logic model_done = 1'b1;
  logic man_done = 1'b1;
  assign tx_done_in = auto_en ? model_done : man_done;

  int errors = 0;
  int checks = 0;
  int rdy0_cnt = 0;
  int rdy1_cnt = 0;

  always #5 hwclk = ~hwclk;

  uart_tx_sched dut (
    .hwclk(hwclk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx_byte(tx_byte), .tx_send(tx_send), .tx_done_in(tx_done_in),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  uart_tx_sched #(.TIMEOUT_CYCLES(20), .TO_W(5)) dut_t (
    .hwclk(hwclk), .rst_n(rst_n),
    .req0_valid(t_req0_valid), .req0_data(t_req0_data), .req0_ready(t_req0_ready),
    .req1_valid(1'b0), .req1_data(8'h00), .req1_ready(t_req1_ready),
    .tx_byte(t_tx_byte), .tx_send(t_tx_send), .tx_done_in(1'b1),
    .busy(t_busy), .grant_id(t_grant_id), .timeout_err(t_timeout_err), .err_clr(t_err_clr)
  );

  // Transmitter model: done drops 3 cycles after send is seen, rises 50 later.
  initial begin
    forever begin
      @(posedge hwclk);
      #1;
      if (auto_en && tx_send && model_done) begin
        repeat (3) begin @(posedge hwclk); #1; end
        model_done = 1'b0;
        repeat (50) begin @(posedge hwclk); #1; end
        model_done = 1'b1;
      end
    end
  end

  always @(negedge hwclk) begin
    if (req0_ready) rdy0_cnt++;
    if (req1_ready) rdy1_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       r0v;
    logic [7:0] r0d;
    logic       r1v;
    logic [7:0] r1d;
    logic       eg;
    logic [7:0] eb;
  } vec_t;

  vec_t tbl [7];

  // One table transfer: wait for a ready, check grant, then follow the frame.
  task automatic run_vec(input int idx);
    vec_t v;
    bit   got;
    bit   fin;
    bit   byte_bad;
    bit   rdy_bad;
    int   send_hi;
    int   k;
    logic g;
    v = tbl[idx];
    req0_valid = v.r0v; req0_data = v.r0d;
    req1_valid = v.r1v; req1_data = v.r1d;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge hwclk);
      if (req0_ready || req1_ready) got = 1;
    end
    check($sformatf("v%0d_ready_seen", idx), 32'(got), 32'd1);
    if (got) begin
      g = req1_ready;
      check($sformatf("v%0d_grant_port", idx), 32'(g), 32'(v.eg));
      check($sformatf("v%0d_ready_onehot", idx), 32'(req0_ready & req1_ready), 32'd0);
      check($sformatf("v%0d_tx_byte", idx), 32'(tx_byte), 32'(v.eb));
      check($sformatf("v%0d_grant_id", idx), 32'(grant_id), 32'(v.eg));
      check($sformatf("v%0d_busy", idx), 32'(busy), 32'd1);
      check($sformatf("v%0d_send_lo_at_ready", idx), 32'(tx_send), 32'd0);
      if (g) req1_valid = 1'b0; else req0_valid = 1'b0;
      send_hi = 0; byte_bad = 0; rdy_bad = 0; fin = 0; k = 0;
      for (int i = 1; i <= 200 && !fin; i++) begin
        @(negedge hwclk);
        if (tx_send) send_hi++;
        if (tx_byte !== v.eb) byte_bad = 1;
        if (req0_ready || req1_ready) rdy_bad = 1;
        if (!busy) begin fin = 1; k = i; end
      end
      check($sformatf("v%0d_send_cycles", idx), 32'(send_hi), 32'd6);
      check($sformatf("v%0d_busy_cycles", idx), 32'(k), 32'd57);
      check($sformatf("v%0d_byte_stable", idx), 32'(byte_bad), 32'd0);
      check($sformatf("v%0d_single_ready", idx), 32'(rdy_bad), 32'd0);
      check($sformatf("v%0d_no_err", idx), 32'(timeout_err), 32'd0);
    end
  endtask

  task automatic wait_idle(input string name);
    bit fin;
    fin = 0;
    for (int i = 0; i < 200 && !fin; i++) begin
      @(negedge hwclk);
      if (!busy) fin = 1;
    end
    check(name, 32'(fin), 32'd1);
  endtask

  initial begin
    int exp0;
    int exp1;
    bit got;
    bit early;
    bit rise;
    int cyc;

    // {r0v, r0d, r1v, r1d, expected grant, expected byte}
`ifdef UART_TX_SCHED_RR_EN
    tbl[0] = '{1'b1, 8'h30, 1'b0, 8'h00, 1'b0, 8'h30};
    tbl[1] = '{1'b1, 8'h41, 1'b1, 8'h35, 1'b1, 8'h35};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 8'h35, 1'b1, 8'h35};
    tbl[3] = '{1'b1, 8'h30, 1'b1, 8'h31, 1'b0, 8'h30};
    tbl[4] = '{1'b1, 8'h32, 1'b1, 8'h33, 1'b1, 8'h33};
    tbl[5] = '{1'b1, 8'h34, 1'b1, 8'h35, 1'b0, 8'h34};
    tbl[6] = '{1'b1, 8'h36, 1'b1, 8'h37, 1'b1, 8'h37};
`else
    tbl[0] = '{1'b1, 8'h30, 1'b0, 8'h00, 1'b0, 8'h30};
    tbl[1] = '{1'b1, 8'h41, 1'b1, 8'h35, 1'b0, 8'h41};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 8'h35, 1'b1, 8'h35};
    tbl[3] = '{1'b1, 8'h30, 1'b1, 8'h31, 1'b0, 8'h30};
    tbl[4] = '{1'b1, 8'h32, 1'b1, 8'h33, 1'b0, 8'h32};
    tbl[5] = '{1'b1, 8'h34, 1'b1, 8'h35, 1'b0, 8'h34};
    tbl[6] = '{1'b1, 8'h36, 1'b1, 8'h37, 1'b0, 8'h36};
`endif

    // reset values
    repeat (3) @(negedge hwclk);
    check("rst_tx_send", 32'(tx_send), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_err", 32'(timeout_err), 32'd0);
    check("rst_t_err", 32'(t_timeout_err), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge hwclk);

    // table-driven transfers
    exp0 = 0; exp1 = 0;
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].eg) exp1++; else exp0++;
      run_vec(i);
    end
    check("ready0_total", 32'(rdy0_cnt), 32'(exp0));
    check("ready1_total", 32'(rdy1_cnt), 32'(exp1));
    req0_valid = 1'b0; req1_valid = 1'b0;

    // reset in WAIT_DONE
    req1_valid = 1'b1; req1_data = 8'h55;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge hwclk);
      if (req1_ready) got = 1;
    end
    check("mr_ready_seen", 32'(got), 32'd1);
    req1_valid = 1'b0;
    repeat (10) @(negedge hwclk);
    check("mr_pre_busy", 32'(busy), 32'd1);
    check("mr_pre_done_low", 32'(tx_done_in), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mr_tx_send", 32'(tx_send), 32'd0);
    check("mr_tx_byte", 32'(tx_byte), 32'd0);
    check("mr_ready1", 32'(req1_ready), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_grant", 32'(grant_id), 32'd0);
    check("mr_err", 32'(timeout_err), 32'd0);
    repeat (2) @(posedge hwclk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge hwclk);
    req1_valid = 1'b1; req1_data = 8'h37;
    got = 0; early = 0; rise = 0; cyc = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge hwclk);
      if (!rise && tx_done_in) begin rise = 1; cyc = 0; end
      else if (rise) cyc++;
      if (req1_ready) begin
        got = 1;
        if (!rise) early = 1;
      end
    end
    check("mr_grant_seen", 32'(got), 32'd1);
    check("mr_no_early_grant", 32'(early), 32'd0);
    check("mr_grant_latency", 32'(cyc), 32'd3);
    check("mr_tx_byte_new", 32'(tx_byte), 32'h37);
    req1_valid = 1'b0;
    wait_idle("mr_finish");

    // start gated by done low
    @(negedge hwclk);
    man_done = 1'b1;
    auto_en = 1'b0;
    man_done = 1'b0;
    repeat (4) @(negedge hwclk);
    req1_valid = 1'b1; req1_data = 8'h32;
    early = 0;
    repeat (6) begin
      @(negedge hwclk);
      if (req1_ready || req0_ready) early = 1;
    end
    check("gate_no_ready", 32'(early), 32'd0);
    check("gate_idle", 32'(busy), 32'd0);
    @(posedge hwclk);
    #1 man_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge hwclk);
      check($sformatf("gate_ready_c%0d", i), 32'(req1_ready), 32'(i == 3));
    end
    auto_en = 1'b1;
    req1_valid = 1'b0;
    check("gate_tx_byte", 32'(tx_byte), 32'h32);
    wait_idle("gate_finish");

    // watchdog timeout on the short-timeout instance
    t_req0_valid = 1'b1; t_req0_data = 8'h39;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge hwclk);
      if (t_req0_ready) got = 1;
    end
    check("to_ready_seen", 32'(got), 32'd1);
    t_req0_valid = 1'b0;
    repeat (20) @(negedge hwclk);
    check("to_send_before", 32'(t_tx_send), 32'd1);
    check("to_err_before", 32'(t_timeout_err), 32'd0);
    @(negedge hwclk);
    check("to_err_set", 32'(t_timeout_err), 32'd1);
    check("to_send_dropped", 32'(t_tx_send), 32'd0);
    check("to_idle", 32'(t_busy), 32'd0);
    repeat (4) @(negedge hwclk);
    check("to_err_sticky", 32'(t_timeout_err), 32'd1);
    t_err_clr = 1'b1;
    @(negedge hwclk);
    check("to_err_cleared", 32'(t_timeout_err), 32'd0);

    // clear held across a second timeout: set takes priority
    t_req0_valid = 1'b1; t_req0_data = 8'h38;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge hwclk);
      if (t_req0_ready) got = 1;
    end
    check("to2_ready_seen", 32'(got), 32'd1);
    t_req0_valid = 1'b0;
    repeat (20) @(negedge hwclk);
    check("to2_err_before", 32'(t_timeout_err), 32'd0);
    @(negedge hwclk);
    check("to2_set_wins", 32'(t_timeout_err), 32'd1);
    @(negedge hwclk);
    check("to2_clr_after", 32'(t_timeout_err), 32'd0);
    t_err_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
